// File: rtl/regfile_stacker_if.sv
// Wishbone classic bus bundle between the register stacker and the data bus arbiter.
interface regfile_stacker_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] adr_o;
  logic [WIDTH-1:0] dat_o;
  logic [WIDTH-1:0] dat_i;
  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic [3:0]       sel_o;
  logic             ack_i;

  modport master (
    output adr_o, dat_o, cyc_o, stb_o, we_o, sel_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, cyc_o, stb_o, we_o, sel_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/regfile_stacker.sv
// Exception entry/return sequencer: pushes masked registers onto the supervisor
// stack (descending, pre-decrement) and pops them back (ascending, post-increment).
module regfile_stacker #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned COUNTP = 4,
  parameter int unsigned SPREG  = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   save_req,
  input  logic                   restore_req,
  input  logic [15:0]            mask,
  input  logic [WIDTH-1:0]       sp_in,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       sp_out,
  output logic                   sp_we,
  output logic [COUNTP-1:0]      rf_raddr,
  input  logic [WIDTH-1:0]       rf_rdata,
  output logic [COUNTP-1:0]      rf_waddr,
  output logic [WIDTH-1:0]       rf_wdata,
  output logic [1:0]             rf_we,
  regfile_stacker_if.master      wb
);

  localparam int unsigned MASKW = 16;

  typedef enum logic [2:0] {IDLE, SV_RD, SV_BUS, RS_BUS, RS_WB, FINISH} state_t;

  state_t             state_q, state_d;
  logic [MASKW-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d, done_q, done_d, sp_we_q, sp_we_d;
  logic [WIDTH-1:0]   sp_out_q, sp_out_d;
  logic [COUNTP-1:0]  rf_raddr_q, rf_raddr_d, rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic [1:0]         rf_we_q, rf_we_d;
  logic [WIDTH-1:0]   adr_q, adr_d, dat_q, dat_d;
  logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]         sel_q, sel_d;

  logic [MASKW-1:0]   mask_lat, mask_clr_sv, mask_clr_rs;
  logic [WIDTH-1:0]   sp_aligned, ptr_dn, ptr_up;

  function automatic logic [COUNTP-1:0] hi_idx(input logic [MASKW-1:0] m);
    hi_idx = '0;
    for (int i = 0; i < int'(MASKW); i++) begin
      if (m[i]) hi_idx = COUNTP'(i);
    end
  endfunction

  function automatic logic [COUNTP-1:0] lo_idx(input logic [MASKW-1:0] m);
    lo_idx = '0;
    for (int i = int'(MASKW) - 1; i >= 0; i--) begin
      if (m[i]) lo_idx = COUNTP'(i);
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sp_we_d    = 1'b0;
    sp_out_d   = sp_out_q;
    rf_raddr_d = rf_raddr_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_we_d    = 2'b00;
    adr_d      = adr_q;
    dat_d      = dat_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;

    mask_lat        = mask;
    mask_lat[SPREG] = 1'b0;
    mask_clr_sv     = mask_q;
    mask_clr_sv[rf_raddr_q] = 1'b0;
    mask_clr_rs     = mask_q;
    mask_clr_rs[rf_waddr_q] = 1'b0;
    sp_aligned      = sp_in & ~WIDTH'(3);
    ptr_dn          = ptr_q - WIDTH'(4);
    ptr_up          = ptr_q + WIDTH'(4);

    case (state_q)
      IDLE: begin
        if (save_req || restore_req) begin
          mask_d = mask_lat;
          ptr_d  = sp_aligned;
          busy_d = 1'b1;
          if (mask_lat == '0) begin
            state_d  = FINISH;
            sp_out_d = sp_aligned;
            sp_we_d  = 1'b1;
            done_d   = 1'b1;
          end else if (save_req) begin
            state_d    = SV_RD;
            rf_raddr_d = hi_idx(mask_lat);
          end else begin
            state_d = RS_BUS;
            adr_d   = sp_aligned;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = 4'hf;
          end
        end
      end
      SV_RD: begin
        dat_d   = rf_rdata;
        adr_d   = ptr_dn;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        sel_d   = 4'hf;
        state_d = SV_BUS;
      end
      SV_BUS: begin
        if (wb.ack_i) begin
          ptr_d  = ptr_dn;
          mask_d = mask_clr_sv;
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          we_d   = 1'b0;
          sel_d  = 4'h0;
          if (mask_clr_sv != '0) begin
            state_d    = SV_RD;
            rf_raddr_d = hi_idx(mask_clr_sv);
          end else begin
            state_d  = FINISH;
            sp_out_d = ptr_dn;
            sp_we_d  = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      RS_BUS: begin
        if (wb.ack_i) begin
          rf_wdata_d = wb.dat_i;
          rf_waddr_d = lo_idx(mask_q);
          rf_we_d    = 2'b11;
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          sel_d      = 4'h0;
          state_d    = RS_WB;
        end
      end
      RS_WB: begin
        ptr_d  = ptr_up;
        mask_d = mask_clr_rs;
        if (mask_clr_rs != '0) begin
          state_d = RS_BUS;
          adr_d   = ptr_up;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hf;
        end else begin
          state_d  = FINISH;
          sp_out_d = ptr_up;
          sp_we_d  = 1'b1;
          done_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sp_we_q    <= 1'b0;
      sp_out_q   <= '0;
      rf_raddr_q <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_we_q    <= 2'b00;
      adr_q      <= '0;
      dat_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sp_we_q    <= sp_we_d;
      sp_out_q   <= sp_out_d;
      rf_raddr_q <= rf_raddr_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_we_q    <= rf_we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sp_we    = sp_we_q;
  assign sp_out   = sp_out_q;
  assign rf_raddr = rf_raddr_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_we    = rf_we_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = stb_q;
  assign wb.we_o  = we_q;
  assign wb.sel_o = sel_q;

endmodule

// File: doc/regfile_stacker.md
Name: regfile_stacker

Overview:
- Exception-entry/return sequencer for the bexkat2 core.
- Reads selected general registers out of the register file and pushes them onto the supervisor stack over a Wishbone classic master port (save).
- Pops them back from the stack and writes them into the register file (restore).
- Sits between the control unit, the register file read/write ports and the data bus arbiter. It is the reader/writer counterpart of the register file's storage.

Parameters:
- WIDTH, 32, register and bus data width
- COUNTP, 4, register address width
- SPREG, 15, index of stack pointer register; never saved or restored via the mask

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- save_req  in  1  start save sequence (single-cycle pulse)
- restore_req  in  1  start restore sequence (single-cycle pulse)
- mask  in  16  register select, bit i = register i; sampled at start
- sp_in  in  WIDTH  current supervisor stack pointer; sampled at start
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on completion
- sp_out  out  WIDTH  final stack pointer
- sp_we  out  1  one-cycle write strobe for sp_out, coincident with done
- rf_raddr  out  COUNTP  register file read address
- rf_rdata  in  WIDTH  register file read data (combinational from rf_raddr)
- rf_waddr  out  COUNTP  register file write address
- rf_wdata  out  WIDTH  register file write data
- rf_we  out  2  register file write enable; 2'b11 = word, 2'b00 = none
- adr_o  out  WIDTH  bus address
- dat_o  out  WIDTH  bus write data
- dat_i  in  WIDTH  bus read data
- cyc_o, stb_o  out  1  bus cycle/strobe
- we_o  out  1  bus write
- sel_o  out  4  byte selects; always 4'hf during a cycle, 4'h0 otherwise
- ack_i  in  1  bus acknowledge

Behaviour:
- Reset (async): state IDLE; busy, done, sp_we, cyc_o, stb_o, we_o = 0; rf_we = 2'b00; sel_o = 0; sp_out, adr_o, dat_o, rf_wdata, rf_raddr, rf_waddr = 0. Reset mid-sequence abandons any bus cycle immediately. No partial restore is undone.
- States: IDLE, SV_RD, SV_BUS, RS_BUS, RS_WB, FINISH.
- IDLE:
  - save_req latches mask with bit SPREG forced 0, and ptr = {sp_in[WIDTH-1:2], 2'b00}.
  - Save has priority if save_req and restore_req are both high; restore_req uses the same latch.
  - busy goes high the next cycle.
  - If the latched mask is zero, go directly to FINISH.
- Requests while busy are ignored.
- Save order: highest set index first, descending. Pre-decrement addressing.
  - SV_RD (1 cycle): rf_raddr = idx; register dat_o <= rf_rdata and adr_o <= ptr-4.
  - SV_BUS: cyc_o = stb_o = we_o = 1 until ack_i. On ack: ptr <= ptr-4, clear mask bit idx, then go to SV_RD for the next set bit or to FINISH if none remain.
  - Minimum 2 cycles per register.
- Restore order: lowest set index first, ascending. Post-increment addressing.
  - RS_BUS: adr_o = ptr, cyc_o = stb_o = 1, we_o = 0 until ack_i. On ack: rf_wdata <= dat_i, rf_waddr <= idx.
  - RS_WB (1 cycle): rf_we = 2'b11; ptr <= ptr+4; clear mask bit; then RS_BUS for the next bit or FINISH.
- FINISH (1 cycle): sp_out = ptr, sp_we = 1, done = 1, busy = 1. Next cycle IDLE with busy = 0.
- ptr arithmetic is modulo 2^WIDTH; wrap through 0 is permitted and not flagged.
- Bus stalls of any length are supported; outputs are held stable while waiting for ack_i.
- rf_we is nonzero only in RS_WB. Bus signals are deasserted in all other states.

Test Plan:
- Save, mask=16'h8003, sp_in=32'h1000, r0=0xA0, r1=0xA1, ack_i zero-wait -> writes r1@0xFFC then r0@0xFF8. Bit 15 is ignored. sp_out=0xFF8 with sp_we/done pulse. No rf_we activity.
- Restore, mask=16'h0003, sp_in=0xFF8, memory 0xFF8=0xB0 and 0xFFC=0xB1 -> reads 0xFF8 then 0xFFC; rf_we=2'b11 writes r0=0xB0, then r1=0xB1; sp_out=0x1000.
- Zero mask, save, sp_in=0x2003 -> no bus cycle; done and sp_we after 2 cycles; sp_out=0x2000 (alignment).
- Save of r14 with ack_i delayed 5 cycles -> adr_o/dat_o/cyc_o stable throughout; busy held; sp_out=sp_in-4.
- save_req and restore_req together, then save_req again while busy -> save executes once; second request ignored; exactly one done.
- rst_i asserted while in SV_BUS -> cyc_o/stb_o/busy drop asynchronously; after release, a new save runs normally from IDLE.
